// File: rtl/mips_register_file_pkg.sv
// Shared MiniMIPS definitions: datapath widths and named architectural register indices.
// Imported by the decoder, register file and ALU wrappers.
package mips_register_file_pkg;

    localparam int MIPS_DATA_WIDTH     = 32;
    localparam int MIPS_REG_ADDR_WIDTH = 5;

    typedef enum logic [MIPS_REG_ADDR_WIDTH-1:0] {
        REG_ZERO = 5'd0,
        REG_AT   = 5'd1,
        REG_SP   = 5'd29,
        REG_RA   = 5'd31
    } reg_name_e;

endpackage

// File: rtl/mips_register_file_if.sv
// Register-file access bundle: two read ports (rs, rt) and one write-back port.
// Purely combinational reads, so there is no handshake or backpressure on this bus.
interface mips_register_file_if
    import mips_register_file_pkg::*;
#(
    parameter int DATA_WIDTH = MIPS_DATA_WIDTH,
    parameter int ADDR_WIDTH = MIPS_REG_ADDR_WIDTH
);
  logic [ADDR_WIDTH-1:0] read_reg1;
  logic [ADDR_WIDTH-1:0] read_reg2;
  logic [ADDR_WIDTH-1:0] write_reg;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  reg_write;
  logic [DATA_WIDTH-1:0] read_data1;
  logic [DATA_WIDTH-1:0] read_data2;

  modport master (
      output read_reg1, read_reg2, write_reg, write_data, reg_write,
      input  read_data1, read_data2
  );

  modport slave (
      input  read_reg1, read_reg2, write_reg, write_data, reg_write,
      output read_data1, read_data2
  );
endinterface

// File: rtl/mips_register_file_reg_read_port.sv
// One combinational read port: zero-forces index 0 and optionally forwards a same-cycle write.
// Zero latency; no backpressure.
module mips_register_file_reg_read_port
    import mips_register_file_pkg::*;
#(
    parameter int DATA_WIDTH = MIPS_DATA_WIDTH,
    parameter int ADDR_WIDTH = MIPS_REG_ADDR_WIDTH,
    parameter bit BYPASS     = 1'b1
) (
  input  logic [ADDR_WIDTH-1:0] read_idx,
  input  logic [ADDR_WIDTH-1:0] write_idx,
  input  logic [DATA_WIDTH-1:0] write_dat,
  input  logic                  write_en,
  input  logic [DATA_WIDTH-1:0] regs [2**ADDR_WIDTH],
  output logic [DATA_WIDTH-1:0] read_dat
);
  // write_en arrives already qualified with !reset and a non-zero index
  always_comb begin
    read_dat = '0;
    if (read_idx == ADDR_WIDTH'(REG_ZERO)) begin
      read_dat = '0;
    end else if (BYPASS && write_en && (write_idx == read_idx)) begin
      read_dat = write_dat;
    end else begin
      read_dat = regs[read_idx];
    end
  end
endmodule

// File: rtl/mips_register_file.sv
// 2-read/1-write MiniMIPS register file, r0 hardwired to zero; reads are zero-latency.
// Writes land on the rising edge; synchronous reset wins over a coincident write.
module mips_register_file
    import mips_register_file_pkg::*;
#(
    parameter int DATA_WIDTH = MIPS_DATA_WIDTH,
    parameter int ADDR_WIDTH = MIPS_REG_ADDR_WIDTH,
    parameter bit BYPASS     = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  mips_register_file_if.slave  bus
);
  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic                  write_en;

  assign write_en = bus.reg_write && !reset && (bus.write_reg != ADDR_WIDTH'(REG_ZERO));

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (write_en) begin
      regs[bus.write_reg] <= bus.write_data;
    end
  end

  mips_register_file_reg_read_port #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .BYPASS    (BYPASS)
  ) u_rs_port (
      .read_idx (bus.read_reg1),
      .write_idx(bus.write_reg),
      .write_dat(bus.write_data),
      .write_en (write_en),
      .regs     (regs),
      .read_dat (bus.read_data1)
  );

  mips_register_file_reg_read_port #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .BYPASS    (BYPASS)
  ) u_rt_port (
      .read_idx (bus.read_reg2),
      .write_idx(bus.write_reg),
      .write_dat(bus.write_data),
      .write_en (write_en),
      .regs     (regs),
      .read_dat (bus.read_data2)
  );
endmodule
